hilbert_transform_filter: RTL and testbench
===========================================

Name: hilbert_transform_filter

Overview:
- Real-to-analytic-signal converter: a fixed-coefficient, odd-length Hilbert FIR.
- Takes a real signed sample stream and produces a complex pair:
  - Re = input delayed by the group delay and scaled;
  - Im = Hilbert-filtered input, at the same scale.
- Sits between the sample source and the complex matched-filter FIR in the pulse-compression chain.

Parameters:
- LENGTH, 27, number of FIR taps; must be odd and at least 3. Group delay D = (LENGTH-1)/2.
- DATA_WIDTH, 12, signed input sample width and coefficient width.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  sample-valid/advance; one sample accepted per clock while high.
- stopDataInFlag  input  1  freeze request; when high, no sample is accepted. Tie to 0 if unused.
- dataIn  input  DATA_WIDTH  signed two's-complement real sample.
- dataOutRe  output  3*DATA_WIDTH  signed real (in-phase) output.
- dataOutIm  output  3*DATA_WIDTH  signed imaginary (quadrature) output.

Behaviour:
- Coefficients: constant table h[k], k=0..LENGTH-1, with m = k-D.
  - h[k] = round(2^(DATA_WIDTH-2) * 2/(pi*m)) for odd m; h[k] = 0 for even m (including m=0).
  - Antisymmetric: h[k] = -h[LENGTH-1-k]. Rounding is half away from zero.
  - DATA_WIDTH=12, m=1,3,5,7,9,11,13 gives 652, 217, 130, 93, 72, 59, 50. Negative m gives the negated values.
- Delay line: taps x[0..LENGTH-2] hold the previous samples, signed DATA_WIDTH.
- Advance condition: adv = enable & ~stopDataInFlag.
- On a clock with adv=1:
  - Window w[0] = dataIn, w[j] = x[j-1] for j >= 1.
  - dataOutIm <= sum over k of h[k]*w[k], full precision, sign-extended to 3*DATA_WIDTH.
  - dataOutRe <= w[D] * 2^(DATA_WIDTH-2), sign-extended.
  - The taps shift: x[0] <= dataIn, x[j] <= x[j-1].
- Latency: an output reflects the sample accepted on the same edge, so it is visible one clock after that sample is presented. The Re and Im paths are aligned.
- adv=0 (enable low or stopDataInFlag high): taps and both outputs hold their values; no sample is consumed. stopDataInFlag has priority over enable.
- Reset (synchronous, highest priority): all taps = 0, dataOutRe = 0, dataOutIm = 0.
  - Reset mid-stream discards history.
  - The next accepted sample starts from a zero-filled window.
- Arithmetic:
  - Products are 2*DATA_WIDTH bits; the accumulator is 3*DATA_WIDTH bits.
  - No saturation or rounding on the output; the width is guaranteed sufficient for the default parameters.
  - Zero-valued even-offset taps may be omitted from the adder tree. Results must be bit-identical.
- Optional pipelining inside the adder tree is allowed only if the one-clock output latency is preserved. Default: a single registered stage.
- Startup: for the first D accepted samples after reset, dataOutRe reflects the zero-filled history and equals 0.

Decomposition:
- Shared package hilbert_pkg:
  - coefficient function hilbert_coeff(k, LENGTH, DATA_WIDTH);
  - localparams for D and the output width.
- One natural sub-module: tapped_delay_line, a parameterised signed shift register with advance enable and synchronous reset.
- The MAC sum stays in the top module.

Test Plan:
- Reset: drive dataIn=2047 with enable=0 and reset=1 for 3 clocks, then release reset → dataOutRe=0 and dataOutIm=0 throughout.
- Impulse: after reset, adv=1, dataIn=1 for one sample, then zeros.
  - Im outputs over 27 samples: -50, 0, -59, 0, -72, 0, -93, 0, -130, 0, -217, 0, -652, 0, 652, 0, 217, 0, 130, 0, 93, 0, 72, 0, 59, 0, 50.
  - Re = 1024 on the 14th output only, 0 otherwise.
- DC full scale: dataIn held at 2047, then at -2048, for 40 samples → Im settles to 0 after 27 samples. Re settles to 2047*1024=2096128, then -2048*1024=-2097152.
- Worst-case magnitude: pattern sign(h[26-j])*full-scale sampled so it aligns with the coefficients → Im equals the exact sum of |h|*2047 or 2048 with no overflow. Compare against the reference model.
- Stall: insert enable=0 and stopDataInFlag=1 cycles mid-impulse-response → outputs hold. The resumed sequence is identical to the unstalled impulse run.
- Random: 2000 random signed samples with random adv gaps → bit-exact match to the software model of the defined equations.

Source files
------------

// File: rtl/hilbert_pkg.sv
// Shared constants and helpers for the Hilbert real-to-analytic converter:
// group delay, output width and the constant coefficient generator.
package hilbert_pkg;

  localparam int DEFAULT_LENGTH     = 27;
  localparam int DEFAULT_DATA_WIDTH = 12;

  localparam real PI = 3.14159265358979323846;

  // Centre tap index of an odd-length FIR; also the Re-path delay.
  function automatic int group_delay(input int length);
    return (length - 1) / 2;
  endfunction

  // Accumulator / output width for a given sample width.
  function automatic int out_width(input int data_width);
    return 3 * data_width;
  endfunction

  localparam int DEFAULT_DELAY     = group_delay(DEFAULT_LENGTH);
  localparam int DEFAULT_OUT_WIDTH = out_width(DEFAULT_DATA_WIDTH);

  // Coefficient h[k] = round(2^(dw-2) * 2/(pi*m)), m = k - D, zero for even m.
  // Rounding is half away from zero; the magnitude is rounded and the sign
  // reapplied so that h[k] = -h[LENGTH-1-k] holds exactly.
  function automatic int hilbert_coeff(input int k, input int length,
                                       input int data_width);
    int  m;
    int  m_abs;
    int  mag_int;
    real mag;
    m = k - group_delay(length);
    if ((m % 2) == 0) return 0;
    m_abs   = (m < 0) ? -m : m;
    mag     = real'(longint'(1) << (data_width - 1)) / (PI * real'(m_abs));
    mag_int = $rtoi(mag + 0.5);
    return (m < 0) ? -mag_int : mag_int;
  endfunction

endpackage

// File: rtl/hilbert_transform_filter_if.sv
// Sample-in / complex-out bus of the Hilbert converter. The master is the
// sample source (and consumer of the analytic pair); the slave is the filter.
interface hilbert_transform_filter_if #(
  parameter int DATA_WIDTH = 12
);

  logic                              enable;
  logic                              stopDataInFlag;
  logic signed [DATA_WIDTH-1:0]      dataIn;
  logic signed [3*DATA_WIDTH-1:0]    dataOutRe;
  logic signed [3*DATA_WIDTH-1:0]    dataOutIm;

  modport master (
    output enable,
    output stopDataInFlag,
    output dataIn,
    input  dataOutRe,
    input  dataOutIm
  );

  modport slave (
    input  enable,
    input  stopDataInFlag,
    input  dataIn,
    output dataOutRe,
    output dataOutIm
  );

endinterface

// File: rtl/hilbert_transform_filter_tapped_delay_line.sv
// Parameterised signed shift register: taps[0] is the most recent sample.
// Shifts only when advance is high; synchronous active-high reset clears all.
module tapped_delay_line #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 26
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    advance,
  input  logic signed [WIDTH-1:0] din,
  output logic signed [WIDTH-1:0] taps [DEPTH]
);

  // Shift a new sample in on each advance; clear the whole history on reset.
  // NOTE: these taps are real filter state, so they are reset explicitly.
  // A reset mid-stream has to restart from a zero-filled window, which a
  // reset-less RAM-style delay line could not provide.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (advance) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

endmodule

// File: rtl/hilbert_transform_filter.sv
// Real-to-analytic converter: odd-length fixed-coefficient Hilbert FIR.
// Im = sum h[k]*w[k]; Re = centre-tap sample scaled by 2^(DATA_WIDTH-2), so
// both paths carry the same gain and the same group delay. The window includes
// the sample being accepted, so each output appears one clock after its input.
module hilbert_transform_filter
  import hilbert_pkg::*;
#(
  parameter int LENGTH     = DEFAULT_LENGTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  hilbert_transform_filter_if.slave  bus
);

  localparam int DELAY      = group_delay(LENGTH);
  localparam int OUT_WIDTH  = out_width(DATA_WIDTH);
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  logic                          adv;
  logic signed [DATA_WIDTH-1:0]  taps    [LENGTH-1];
  logic signed [DATA_WIDTH-1:0]  window  [LENGTH];
  logic signed [PROD_WIDTH-1:0]  products[LENGTH];
  logic signed [OUT_WIDTH-1:0]   im_sum;
  logic signed [OUT_WIDTH-1:0]   re_next;

  // Freeze has priority: a stopped cycle never consumes a sample.
  assign adv = bus.enable & ~bus.stopDataInFlag;

  tapped_delay_line #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (LENGTH - 1)
  ) u_delay_line (
    .clock   (clock),
    .reset   (reset),
    .advance (adv),
    .din     (bus.dataIn),
    .taps    (taps)
  );

  // Window seen by the MAC: the incoming sample followed by the history.
  always_comb begin
    window[0] = bus.dataIn;
    for (int j = 1; j < LENGTH; j++) window[j] = taps[j-1];
  end

  // One constant-coefficient product per tap; zero taps fold away in synthesis.
  for (genvar k = 0; k < LENGTH; k++) begin : g_tap
    localparam int COEF_INT = hilbert_coeff(k, LENGTH, DATA_WIDTH);
    localparam logic signed [DATA_WIDTH-1:0] COEF = DATA_WIDTH'(COEF_INT);
    assign products[k] = PROD_WIDTH'(COEF) * PROD_WIDTH'(window[k]);
  end

  // Full-precision sum of products; Re is the centre sample times 2^(DW-2).
  // NOTE: every variable written here gets a value before any conditional
  // use, so the block stays purely combinational and infers no latch.
  always_comb begin
    im_sum = '0;
    for (int k = 0; k < LENGTH; k++) begin
      im_sum = im_sum + OUT_WIDTH'(products[k]);
    end
    re_next = {{(DATA_WIDTH + 2){window[DELAY][DATA_WIDTH-1]}},
               window[DELAY],
               {(DATA_WIDTH - 2){1'b0}}};
  end

  // Output register: update on accepted samples, hold otherwise.
  // NOTE: state is assigned with <= so every register samples the values
  // from before the edge, independent of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.dataOutRe <= '0;
      bus.dataOutIm <= '0;
    end else if (adv) begin
      bus.dataOutRe <= re_next;
      bus.dataOutIm <= im_sum;
    end
  end

endmodule

// File: tb/tb_hilbert_transform_filter.sv
// Self-checking bench for hilbert_transform_filter: table-driven reset and
// impulse vectors, hand-written DC / worst-case / stall sequences, and a
// random run, all backed by a queue-based scoreboard fed by a reference model.
module tb_hilbert_transform_filter;

  localparam int LENGTH = 27;
  localparam int DW     = 12;
  localparam int D      = (LENGTH - 1) / 2;
  localparam int OW     = 3 * DW;

  typedef struct {
    logic                 rst;
    logic                 en;
    logic                 stop;
    logic signed [DW-1:0] din;
    longint               exp_re;
    longint               exp_im;
  } vec_t;

  typedef struct {
    longint re;
    longint im;
  } exp_t;

  logic clock;
  logic reset;

  hilbert_transform_filter_if #(.DATA_WIDTH(DW)) bus ();

  hilbert_transform_filter #(
    .LENGTH     (LENGTH),
    .DATA_WIDTH (DW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int     n_checks = 0;
  int     n_errors = 0;
  exp_t   sb_q[$];
  vec_t   vecs[$];
  longint hist[LENGTH-1];
  longint m_re = 0;
  longint m_im = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Independent coefficient table taken from the published values.
  function automatic longint ref_coeff(input int k);
    int mags[7];
    int m;
    int a;
    mags = '{652, 217, 130, 93, 72, 59, 50};
    m = k - D;
    if ((m % 2) == 0) return 0;
    a = (m < 0) ? -m : m;
    return (m < 0) ? -longint'(mags[(a - 1) / 2]) : longint'(mags[(a - 1) / 2]);
  endfunction

  // Reference model of one clock edge; the expected outputs go on the queue.
  task automatic model_step(input logic rst, input logic en, input logic stop,
                            input logic signed [DW-1:0] din);
    longint w[LENGTH];
    longint acc;
    exp_t   e;
    if (rst) begin
      for (int i = 0; i < LENGTH - 1; i++) hist[i] = 0;
      m_re = 0;
      m_im = 0;
    end else if (en && !stop) begin
      w[0] = longint'(din);
      for (int j = 1; j < LENGTH; j++) w[j] = hist[j-1];
      acc = 0;
      for (int k = 0; k < LENGTH; k++) acc += ref_coeff(k) * w[k];
      m_im = acc;
      m_re = w[D] * 1024;
      for (int i = LENGTH - 2; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = longint'(din);
    end
    e.re = m_re;
    e.im = m_im;
    sb_q.push_back(e);
  endtask

  // Drive one clock's inputs at the falling edge, then model the rising edge.
  task automatic step(input logic rst, input logic en, input logic stop,
                      input logic signed [DW-1:0] din);
    @(negedge clock);
    reset              = rst;
    bus.enable         = en;
    bus.stopDataInFlag = stop;
    bus.dataIn         = din;
    @(posedge clock);
    model_step(rst, en, stop, din);
  endtask

  function automatic longint dut_re();
    return longint'(bus.dataOutRe);
  endfunction

  function automatic longint dut_im();
    return longint'(bus.dataOutIm);
  endfunction

  // Scoreboard: compare the DUT against the oldest expected result.
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("sb_re", dut_re(), e.re);
      check("sb_im", dut_im(), e.im);
    end
  end

  // Run-time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic rst, input logic en, input logic stop,
                              input logic signed [DW-1:0] din,
                              input longint er, input longint ei);
    vec_t v;
    v.rst = rst; v.en = en; v.stop = stop; v.din = din;
    v.exp_re = er; v.exp_im = ei;
    return v;
  endfunction

  initial begin
    int imp_im[LENGTH];
    longint last_re;
    longint last_im;
    int accepted;
    logic signed [DW-1:0] s;

    imp_im = '{-50, 0, -59, 0, -72, 0, -93, 0, -130, 0, -217, 0, -652, 0,
               652, 0, 217, 0, 130, 0, 93, 0, 72, 0, 59, 0, 50};

    // Vector table: reset held with full-scale input, release, then impulse.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b1, 1'b0, 1'b0, 12'sd2047, 0, 0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 12'sd2047, 0, 0));
    for (int i = 0; i < LENGTH; i++) begin
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, (i == 0) ? 12'sd1 : 12'sd0,
                        (i == D) ? 64'sd1024 : 64'sd0, longint'(imp_im[i])));
    end

    reset              = 1'b1;
    bus.enable         = 1'b0;
    bus.stopDataInFlag = 1'b0;
    bus.dataIn         = '0;

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].stop, vecs[i].din);
      #1;
      check($sformatf("vec%0d_re", i), dut_re(), vecs[i].exp_re);
      check($sformatf("vec%0d_im", i), dut_im(), vecs[i].exp_im);
    end

    // Worst-case magnitude: inputs follow the coefficient signs at full scale.
    step(1'b1, 1'b0, 1'b0, 12'sd0);
    for (int j = 0; j < LENGTH; j++) begin
      if (ref_coeff(LENGTH - 1 - j) > 0)      s = 12'sd2047;
      else if (ref_coeff(LENGTH - 1 - j) < 0) s = -12'sd2048;
      else                                    s = 12'sd0;
      step(1'b0, 1'b1, 1'b0, s);
    end
    #1;
    check("worst_im", dut_im(), 64'sd5212935);

    // DC full scale, positive then negative.
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b0, 12'sd2047);
      #1;
      if (i >= LENGTH - 1) begin
        check("dc_pos_im", dut_im(), 0);
        check("dc_pos_re", dut_re(), 64'sd2096128);
      end
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b0, -12'sd2048);
      #1;
      if (i >= LENGTH - 1) begin
        check("dc_neg_im", dut_im(), 0);
        check("dc_neg_re", dut_re(), -64'sd2097152);
      end
    end

    // Reset mid-stream, then an impulse with stall cycles inserted.
    step(1'b1, 1'b1, 1'b0, 12'sd2047);
    #1;
    check("midreset_re", dut_re(), 0);
    check("midreset_im", dut_im(), 0);
    accepted = 0;
    while (accepted < LENGTH) begin
      step(1'b0, 1'b1, 1'b0, (accepted == 0) ? 12'sd1 : 12'sd0);
      #1;
      check("stall_seq_re", dut_re(), (accepted == D) ? 64'sd1024 : 64'sd0);
      check("stall_seq_im", dut_im(), longint'(imp_im[accepted]));
      last_re = (accepted == D) ? 64'sd1024 : 64'sd0;
      last_im = longint'(imp_im[accepted]);
      accepted++;
      if (accepted == 3 || accepted == 12 || accepted == 20) begin
        step(1'b0, 1'b0, 1'b0, 12'sd777);
        #1;
        check("hold_en0_im", dut_im(), last_im);
        check("hold_en0_re", dut_re(), last_re);
        step(1'b0, 1'b1, 1'b1, -12'sd555);
        #1;
        check("hold_stop_im", dut_im(), last_im);
        check("hold_stop_re", dut_re(), last_re);
        step(1'b0, 1'b0, 1'b1, 12'sd321);
        #1;
        check("hold_both_im", dut_im(), last_im);
      end
    end

    // Random samples, random advance gaps and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0), DW'($urandom));
    end

    @(negedge clock);
    #1;
    check("sb_drain", longint'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
